// File: rtl/cr_event_counter_bank.sv
// cr_event_counter_bank
//   Multi-channel wide event-counter bank behind a simple register strobe bus.
//   Each channel has its own event strobe and increment. Counters either wrap
//   or saturate, and each channel has a sticky overflow flag. A freeze control
//   stops counting. A snapshot copies every channel at once, so software can
//   read the multi-word values coherently.
//
//   Global register (GLBL_ADDRESS):
//     write: [0] sat, [1] freeze, [2] snapshot pulse, [3] clear_all pulse
//     read : [0] sat, [1] freeze, [3:2] 0, [31:4] ovf_sticky (padded/truncated)
//   Channel registers: BASE_ADDRESS + i*ALIGNMENT + w return 32-bit word w
//   of snap[i]. These registers are read-only.
//
//   Optional macro CR_EVENT_CTR_CLR_ON_RD_EN: when it is defined, a read of the
//   last word of channel i clears live[i] and ovf_sticky[i].
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   reg_addr      register word address
//   wr_stb        one-cycle write strobe; wr_data is the write payload
//   rd_stb        one-cycle read strobe
//   count_stb     per-channel event strobe
//   count_by      per-channel increment, N_COUNT_BY_BITS per channel
//   rd_data       registered read data, held until the next rd_stb
//   rd_hit        pulses with rd_data when the address is mapped
//   ovf_sticky    per-channel sticky overflow flags
module cr_event_counter_bank #(
  parameter int unsigned N_COUNTERS      = 4,
  parameter int unsigned N_COUNTER_BITS  = 50,
  parameter int unsigned N_COUNT_BY_BITS = 4,
  parameter int unsigned N_ADDR_BITS     = 12,
  parameter int unsigned BASE_ADDRESS    = 'h100,
  parameter int unsigned GLBL_ADDRESS    = 'h0FC,
  parameter int unsigned ALIGNMENT       = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_ADDR_BITS-1:0]                reg_addr,
  input  logic                                  wr_stb,
  input  logic                                  rd_stb,
  input  logic [31:0]                           wr_data,
  input  logic [N_COUNTERS-1:0]                 count_stb,
  input  logic [N_COUNTERS*N_COUNT_BY_BITS-1:0] count_by,
  output logic [31:0]                           rd_data,
  output logic                                  rd_hit,
  output logic [N_COUNTERS-1:0]                 ovf_sticky
);

  localparam int unsigned SUM_W = N_COUNTER_BITS + 1;
  localparam int unsigned EXT_W = ALIGNMENT * 32;

  logic [N_COUNTERS-1:0][N_COUNTER_BITS-1:0] live;
  logic [N_COUNTERS-1:0][N_COUNTER_BITS-1:0] live_nxt;
  logic [N_COUNTERS-1:0][N_COUNTER_BITS-1:0] snap;
  logic [N_COUNTERS-1:0]                     ovf_nxt;
  logic [N_COUNTERS-1:0]                     clr_rd;
  logic                                      sat;
  logic                                      freeze;
  logic                                      glbl_sel;
  logic                                      glbl_wr;
  logic                                      do_snap;
  logic                                      do_clear;
  logic [31:0]                               rd_word;
  logic                                      rd_mapped;
  logic [N_COUNTERS+27:0]                    ovf_pad;
  logic                                      unused_wr_bits;

  assign unused_wr_bits = ^wr_data[31:4];

  always_comb begin
    glbl_sel = (reg_addr == N_ADDR_BITS'(GLBL_ADDRESS));
    glbl_wr  = wr_stb && glbl_sel;
    do_snap  = glbl_wr && wr_data[2];
    do_clear = glbl_wr && wr_data[3];
  end

  always_comb begin
    clr_rd = '0;
`ifdef CR_EVENT_CTR_CLR_ON_RD_EN
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      clr_rd[i] = rd_stb &&
                  (reg_addr == N_ADDR_BITS'(BASE_ADDRESS + i*ALIGNMENT + ALIGNMENT - 1));
    end
`endif
  end

  // Next counter values. A clear does not discard an event in the same cycle:
  // the cleared channel loads its increment instead of zero.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic             inc;
    live_nxt = live;
    ovf_nxt  = ovf_sticky;
    sum      = '0;
    inc      = 1'b0;
    for (int unsigned i = 0; i < N_COUNTERS; i++) begin
      inc = count_stb[i] && !freeze;
      sum = {1'b0, live[i]} + SUM_W'(count_by[i*N_COUNT_BY_BITS +: N_COUNT_BY_BITS]);
      if (do_clear || clr_rd[i]) begin
        live_nxt[i] = inc ? N_COUNTER_BITS'(count_by[i*N_COUNT_BY_BITS +: N_COUNT_BY_BITS])
                          : '0;
        ovf_nxt[i]  = 1'b0;
      end else if (inc) begin
        if (sum[SUM_W-1]) begin
          ovf_nxt[i] = 1'b1;
        end
        live_nxt[i] = (sum[SUM_W-1] && sat) ? '1 : sum[N_COUNTER_BITS-1:0];
      end
    end
  end

  assign ovf_pad = (N_COUNTERS + 28)'(ovf_sticky);

  always_comb begin
    logic [EXT_W-1:0] ext;
    rd_word   = '0;
    rd_mapped = 1'b0;
    ext       = '0;
    if (glbl_sel) begin
      rd_word   = {ovf_pad[27:0], 2'b00, freeze, sat};
      rd_mapped = 1'b1;
    end else begin
      for (int unsigned i = 0; i < N_COUNTERS; i++) begin
        for (int unsigned w = 0; w < ALIGNMENT; w++) begin
          if (reg_addr == N_ADDR_BITS'(BASE_ADDRESS + i*ALIGNMENT + w)) begin
            ext                     = '0;
            ext[N_COUNTER_BITS-1:0] = snap[i];
            rd_word                 = ext[32*w +: 32];
            rd_mapped               = 1'b1;
          end
        end
      end
    end
  end

  // Snapshot samples the current (pre-increment, pre-clear) live value.
  // A read and a write to the global register in the same cycle return
  // the value from before the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live       <= '0;
      snap       <= '0;
      ovf_sticky <= '0;
      sat        <= 1'b0;
      freeze     <= 1'b0;
      rd_data    <= '0;
      rd_hit     <= 1'b0;
    end else begin
      live       <= live_nxt;
      ovf_sticky <= ovf_nxt;
      if (do_snap) begin
        snap <= live;
      end
      if (glbl_wr) begin
        sat    <= wr_data[0];
        freeze <= wr_data[1];
      end
      if (rd_stb) begin
        rd_data <= rd_word;
      end
      rd_hit <= rd_stb && rd_mapped;
    end
  end

endmodule
